tinyalu_arbiter: RTL and testbench



---
 rtl/tinyalu_arbiter.sv | 172 +++++++++++++++++
 tb/tb_tinyalu_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin arbiter and start/done sequencer sharing one TinyALU among N_REQ requesters.
// Define TINYALU_ARB_TIMEOUT_EN to add a BUSY watchdog that errors out after TIMEOUT_CYCLES.
module tinyalu_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_A,
  input  logic [8*N_REQ-1:0]   req_B,
  input  logic [3*N_REQ-1:0]   req_op,
  output logic [N_REQ-1:0]     req_ack,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  localparam int unsigned MAX_REQ = 8;

  if (N_REQ < 2 || N_REQ > MAX_REQ || TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("tinyalu_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_NOP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] ptr;

`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
`endif

  // Requester payloads padded to 8 slots so a 3-bit id indexes them exactly
  logic [7:0] a_arr  [MAX_REQ];
  logic [7:0] b_arr  [MAX_REQ];
  logic [2:0] op_arr [MAX_REQ];

  always_comb begin
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      a_arr[i]  = 8'h00;
      b_arr[i]  = 8'h00;
      op_arr[i] = 3'b000;
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      a_arr[i]  = req_A[8*i +: 8];
      b_arr[i]  = req_B[8*i +: 8];
      op_arr[i] = req_op[3*i +: 3];
    end
  end

  // Round-robin pick: first set request at or above ptr, wrapping; scanned high-to-low so the nearest wins
  logic [MAX_REQ-1:0] req_pad;
  logic [3:0]         scan;
  logic [2:0]         pick_id;
  logic               pick_vld;
  logic [2:0]         pick_op;

  always_comb begin
    req_pad  = MAX_REQ'(req_valid);
    pick_vld = |req_valid;
    pick_id  = 3'd0;
    scan     = 4'd0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      scan = 4'(ptr) + 4'(k);
      if (scan >= 4'(N_REQ)) scan = scan - 4'(N_REQ);
      if (req_pad[scan[2:0]]) pick_id = scan[2:0];
    end
    pick_op = op_arr[pick_id];
  end

  function automatic logic [N_REQ-1:0] onehot(input logic [2:0] id);
    logic [MAX_REQ-1:0] v;
    v = MAX_REQ'(1) << id;
    return v[N_REQ-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ptr        <= 3'd0;
      req_ack    <= '0;
      rsp_result <= 16'h0000;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 3'd0;
      alu_A      <= 8'h00;
      alu_B      <= 8'h00;
      alu_op     <= 3'b000;
      alu_start  <= 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_id <= pick_id;
            alu_A    <= a_arr[pick_id];
            alu_B    <= b_arr[pick_id];
            alu_op   <= pick_op;
            busy     <= 1'b1;
`ifdef TINYALU_ARB_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
            if (pick_op == 3'b000) begin
              alu_start <= 1'b1;
              state     <= S_NOP;
            end else if (pick_op <= 3'b100) begin
              alu_start <= 1'b1;
              state     <= S_BUSY;
            end else begin
              // Illegal and rst_op codes never reach the ALU
              rsp_result <= 16'h0000;
              rsp_err    <= 1'b1;
              req_ack    <= onehot(pick_id);
              state      <= S_RESP;
            end
          end
        end
        S_BUSY: begin
          if (alu_done) begin
            alu_start  <= 1'b0;
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            req_ack    <= onehot(grant_id);
            state      <= S_RESP;
          end
`ifdef TINYALU_ARB_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            alu_start  <= 1'b0;
            rsp_result <= 16'h0000;
            rsp_err    <= 1'b1;
            req_ack    <= onehot(grant_id);
            state      <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end
        S_NOP: begin
          alu_start  <= 1'b0;
          rsp_result <= 16'h0000;
          rsp_err    <= 1'b0;
          req_ack    <= onehot(grant_id);
          state      <= S_RESP;
        end
        S_RESP: begin
          req_ack <= '0;
          busy    <= 1'b0;
          ptr     <= (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench for tinyalu_arbiter: directed test-plan steps plus randomized traffic against a
// transaction-level round-robin model. Honors TINYALU_ARB_TIMEOUT_EN for the hung-ALU step.
module tb_tinyalu_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned TCYC = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_A;
  logic [8*N-1:0]   req_B;
  logic [3*N-1:0]   req_op;
  logic [N-1:0]     req_ack;
  logic [15:0]      rsp_result;
  logic             rsp_err;
  logic             busy;
  logic [2:0]       grant_id;
  logic [7:0]       alu_A;
  logic [7:0]       alu_B;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic             alu_done = 1'b0;
  logic [15:0]      alu_result = 16'h0000;

  tinyalu_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TCYC)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_A(req_A), .req_B(req_B), .req_op(req_op),
    .req_ack(req_ack), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return 16'(a & b);
      3'b011:  return 16'(a ^ b);
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int alu_lat(input logic [2:0] op);
    return (op == 3'b100) ? 3 : 1;
  endfunction

  // TinyALU stand-in: done after a fixed latency while start is high; stray done pulses elsewhere
  bit hang = 1'b0;
  int alu_cnt = 0;
  always @(negedge clk) begin
    if (!alu_start) begin
      alu_cnt    = 0;
      alu_done   = ($urandom_range(0, 3) == 0);
      alu_result = 16'($urandom);
    end else if (alu_op == 3'b000) begin
      alu_done   = ($urandom_range(0, 1) == 0);
      alu_result = 16'($urandom);
    end else begin
      alu_cnt++;
      alu_done   = !hang && (alu_cnt == alu_lat(alu_op));
      alu_result = alu_done ? ref_result(alu_op, alu_A, alu_B) : 16'($urandom);
    end
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester payloads and transaction-level model state
  logic [7:0] pa [N];
  logic [7:0] pb [N];
  logic [2:0] pop [N];
  int         tb_ptr;
  bit         out_valid;
  int         out_id, out_age, out_starts, out_lat;
  logic [2:0] out_op;
  logic [15:0] out_res;
  logic       out_err;
  logic       prev_busy, prev_start;
  logic [N-1:0] prev_ack;
  bit         seen_start;
  int         low_run;
  int         ack_log[$];
  logic [15:0] res_log[$];
  logic [15:0] last_res;
  logic       last_err;
  int         last_id;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < int'(N); k++)
      if (v[(p + k) % int'(N)]) return (p + k) % int'(N);
    return -1;
  endfunction

  task automatic clear_model();
    tb_ptr = 0; out_valid = 0; out_age = 0; out_starts = 0;
    prev_busy = 0; prev_start = 0; prev_ack = '0;
    seen_start = 0; low_run = 0;
    ack_log.delete(); res_log.delete();
  endtask

  task automatic pack();
    for (int i = 0; i < int'(N); i++) begin
      req_A[8*i +: 8]  = pa[i];
      req_B[8*i +: 8]  = pb[i];
      req_op[3*i +: 3] = pop[i];
    end
  endtask

  task automatic post(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    pa[id] = a; pb[id] = b; pop[id] = op;
    pack();
    req_valid[id] = 1'b1;
  endtask

  // One clock of observation at the falling edge, then the requester reaction to any ack
  task automatic step();
    logic [N-1:0] one_v;
    int exp_id;
    @(negedge clk);
    one_v = 1;
    if (out_valid) out_age++;
    if (prev_ack != '0) begin
      check("ack_one_cycle", 32'(req_ack), 32'd0);
      check("busy_after_resp", 32'(busy), 32'd0);
    end
    if (busy && !prev_busy) begin
      exp_id = rr_pick(req_valid, tb_ptr);
      check("grant_id", 32'(grant_id), 32'(exp_id));
      if (exp_id >= 0) begin
        check("alu_inputs", 32'({alu_op, alu_A, alu_B}), 32'({pop[exp_id], pa[exp_id], pb[exp_id]}));
        out_valid = 1; out_id = exp_id; out_age = 0; out_starts = 0; out_op = pop[exp_id];
        if (hang && out_op != 3'b000 && out_op <= 3'b100) begin
          out_res = 16'h0000; out_err = 1'b1; out_lat = int'(TCYC);
        end else begin
          out_res = ref_result(out_op, pa[exp_id], pb[exp_id]);
          out_err = (out_op >= 3'b101);
          out_lat = (out_op == 3'b000) ? 1 : (out_op <= 3'b100) ? alu_lat(out_op) : 0;
        end
      end
    end
    if (alu_start && !prev_start) begin
      if (seen_start) check("start_low_gap", 32'(low_run >= 2), 32'd1);
      seen_start = 1;
      out_starts++;
    end
    low_run = alu_start ? 0 : low_run + 1;
    if (req_ack != '0) begin
      if (!out_valid) check("ack_unexpected", 32'(req_ack), 32'd0);
      else begin
        check("ack_vec", 32'(req_ack), 32'(one_v << out_id));
        check("rsp_result", 32'(rsp_result), 32'(out_res));
        check("rsp_err", 32'(rsp_err), 32'(out_err));
        check("busy_in_resp", 32'(busy), 32'd1);
        check("start_low_at_ack", 32'(alu_start), 32'd0);
        check("ack_latency", 32'(out_age), 32'(out_lat));
        check("start_pulses", 32'(out_starts), (out_op <= 3'b100) ? 32'd1 : 32'd0);
        last_res = rsp_result; last_err = rsp_err; last_id = out_id;
        ack_log.push_back(out_id); res_log.push_back(rsp_result);
        tb_ptr = (out_id + 1) % int'(N);
        req_valid[out_id] = 1'b0;
        out_valid = 0;
      end
    end else if (out_valid && out_op != 3'b000 && out_op <= 3'b100) begin
      check("start_hold", 32'(alu_start), 32'd1);
    end
    prev_busy = busy; prev_start = alu_start; prev_ack = req_ack;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((req_valid != '0 || out_valid || busy) && n < limit) begin
      step();
      n++;
    end
    check("drain", 32'({req_valid != '0, out_valid, busy}), 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    clear_model();
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ack"}, 32'(req_ack), 32'd0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_alu_A"}, 32'(alu_A), 32'd0);
    check({tag, "_alu_B"}, 32'(alu_B), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    check({tag, "_alu_start"}, 32'(alu_start), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[4];
    int n;
    int acks_before;
    exp_order = '{0, 1, 3, 0};
    for (int i = 0; i < int'(N); i++) begin pa[i] = 8'h00; pb[i] = 8'h00; pop[i] = 3'b000; end
    pack();
    req_valid = '0;
    reset_n = 1'b1;
    clear_model();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Requester 0: add 0x12 + 0x34
    post(0, 3'b001, 8'h12, 8'h34);
    wait_idle(50);
    check("add_id", 32'(last_id), 32'd0);
    check("add_result", 32'(last_res), 32'h0046);
    check("add_err", 32'(last_err), 32'd0);

    // Requester 2: mul 0xFF * 0xFF
    post(2, 3'b100, 8'hFF, 8'hFF);
    wait_idle(50);
    check("mul_id", 32'(last_id), 32'd2);
    check("mul_result", 32'(last_res), 32'hFE01);

    // Requesters 0, 1, 3 together from reset; 0 re-asserts after its ack
    apply_reset();
    post(0, 3'b011, 8'hF0, 8'h0F);
    post(1, 3'b011, 8'hF0, 8'h0F);
    post(3, 3'b011, 8'hF0, 8'h0F);
    n = 0;
    while (ack_log.size() < 1 && n < 50) begin step(); n++; end
    post(0, 3'b011, 8'hF0, 8'h0F);
    wait_idle(100);
    check("rr_count", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_order_%0d", k), 32'(ack_log[k]), 32'(exp_order[k]));
        check($sformatf("rr_result_%0d", k), 32'(res_log[k]), 32'h00FF);
      end
    end

    // no_op, illegal 110, rst_op 111
    post(3, 3'b000, 8'h55, 8'hAA);
    wait_idle(50);
    check("nop_result", 32'(last_res), 32'd0);
    check("nop_err", 32'(last_err), 32'd0);
    post(3, 3'b110, 8'h55, 8'hAA);
    wait_idle(50);
    check("op110_result", 32'(last_res), 32'd0);
    check("op110_err", 32'(last_err), 32'd1);
    post(3, 3'b111, 8'h55, 8'hAA);
    wait_idle(50);
    check("op111_result", 32'(last_res), 32'd0);
    check("op111_err", 32'(last_err), 32'd1);

    // ALU never answers an add
    hang = 1'b1;
    post(1, 3'b001, 8'h01, 8'h01);
`ifdef TINYALU_ARB_TIMEOUT_EN
    wait_idle(60);
    check("timeout_id", 32'(last_id), 32'd1);
    check("timeout_result", 32'(last_res), 32'd0);
    check("timeout_err", 32'(last_err), 32'd1);
`else
    acks_before = ack_log.size();
    repeat (40) step();
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_no_ack", 32'(ack_log.size()), 32'(acks_before));
    apply_reset();
`endif
    hang = 1'b0;

    // Reset mid-mul, then requesters 0 and 2 together: 0 goes first
    post(1, 3'b010, 8'h3C, 8'h0F);
    wait_idle(50);
    post(2, 3'b100, 8'hFF, 8'hFF);
    step();
    step();
    check("mul_in_flight", 32'({busy, alu_start}), 32'd3);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    req_valid = '0;
    @(negedge clk);
    clear_model();
    reset_n = 1'b1;
    post(2, 3'b100, 8'h10, 8'h10);
    post(0, 3'b001, 8'hFF, 8'h01);
    wait_idle(100);
    check("post_reset_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      check("post_reset_first", 32'(ack_log[0]), 32'd0);
      check("post_reset_second", 32'(ack_log[1]), 32'd2);
      check("post_reset_add", 32'(res_log[0]), 32'h0100);
      check("post_reset_mul", 32'(res_log[1]), 32'h0100);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          post(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      step();
    end
    wait_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
